rf_access_ctrl: RTL

Command-driven initiator for the 8-entry general-purpose register file. It accepts register-transfer commands over a valid/ready interface: MOV, load-immediate, read-out and SWAP. It sequences the register file's `write_en`/`out_en`/select/data ports cycle by cycle and returns a response over a second valid/ready interface. It sits between the instruction decoder and the register file and is the only agent driving the file's control ports.

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_access_ctrl_if.sv | 30 +++
 rtl/rf_access_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file access controller.
// Op/state encodings and register-file geometry.
package rf_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DEPTH  = 8;

  typedef enum logic [1:0] {
    OP_MOV  = 2'd0,
    OP_LDI  = 2'd1,
    OP_RD   = 2'd2,
    OP_SWAP = 2'd3
  } rf_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR_A,
    S_WR_B,
    S_RESP
  } rf_state_t;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Command/response valid-ready bundle between decoder and controller.
// master = command issuer, slave = rf_access_ctrl.
interface rf_access_ctrl_if #(
  parameter int N = 8
);
  import rf_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [RF_ADDR_W-1:0] cmd_ra;
  logic [RF_ADDR_W-1:0] cmd_rb;
  logic [N-1:0]         cmd_imm;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [N-1:0]         rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_ra,
    output cmd_rb, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra,
    input  cmd_rb, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rf_access_ctrl.sv
// Sequences register-file read/write ports for MOV/LDI/RD/SWAP.
// Only agent driving the file's control ports.
module rf_access_ctrl
  import rf_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_access_ctrl_if.slave      bus,
  output logic                 rf_write_en,
  output logic                 rf_out_en,
  output logic [RF_ADDR_W-1:0] rf_sel,
  output logic [N-1:0]         rf_data_in,
  input  logic [N-1:0]         rf_data_out
);

  rf_state_t            state_q, state_d;
  rf_op_t               op_q;
  logic [RF_ADDR_W-1:0] ra_q, rb_q;
  logic [N-1:0]         imm_q;
  logic [N-1:0]         tmp0_q, tmp1_q;
  logic                 accept;

  assign accept = (state_q == S_IDLE) & bus.cmd_valid;

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    rf_write_en   = 1'b0;
    rf_out_en     = 1'b0;
    rf_sel        = '0;
    rf_data_in    = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (rf_op_t'(bus.cmd_op) == OP_LDI)
            state_d = S_WR_B;
          else
            state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        rf_out_en = 1'b1;
        rf_sel    = ra_q;
        unique case (1'b1)
          op_q == OP_MOV:  state_d = S_WR_B;
          op_q == OP_SWAP: state_d = S_RD_B;
          default:         state_d = S_RESP;
        endcase
      end
      S_RD_B: begin
        rf_out_en = 1'b1;
        rf_sel    = rb_q;
        state_d   = S_WR_A;
      end
      S_WR_A: begin
        rf_write_en = 1'b1;
        rf_sel      = ra_q;
        rf_data_in  = tmp1_q;
        state_d     = S_WR_B;
      end
      S_WR_B: begin
        rf_write_en = 1'b1;
        rf_sel      = rb_q;
        rf_data_in  = (op_q == OP_LDI) ? imm_q : tmp0_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_MOV;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= rf_op_t'(bus.cmd_op);
      ra_q  <= bus.cmd_ra;
      rb_q  <= bus.cmd_rb;
      imm_q <= bus.cmd_imm;
    end
  end

  // tmp0 ends every op holding the response value, so it is the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmp0_q <= '0;
      tmp1_q <= '0;
    end else begin
      if (state_q == S_RD_A) tmp0_q <= rf_data_out;
      if (state_q == S_RD_B) tmp1_q <= rf_data_out;
      if (state_q == S_WR_B) tmp0_q <= rf_data_in;
    end
  end

  assign bus.rsp_data = tmp0_q;

endmodule
